// File: rtl/cva5_config.sv
// Core configuration constants used by the load/store queue.
package cva5_config;
  localparam int LSQ_STORE_HASH_DEPTH = 4;
endpackage

// File: rtl/cva5_types.sv
// Shared LSQ types: the reduced address hash used for store/load overlap checks.
package cva5_types;
  typedef logic [3:0] addr_hash_t;
endpackage

// File: rtl/store_hash_queue_if.sv
// Issue/commit/query bundle between the LSQ control and the store hash queue.
interface store_hash_queue_if #(
  parameter int DEPTH = cva5_config::LSQ_STORE_HASH_DEPTH
);
  import cva5_types::*;

  logic             push;
  addr_hash_t       push_hash;
  logic             pop;
  logic             load_valid;
  addr_hash_t       load_hash;
  logic             full;
  logic             empty;
  logic [DEPTH-1:0] conflict_mask;
  logic             conflict;

  modport master (
    output push, push_hash, pop, load_valid, load_hash,
    input  full, empty, conflict_mask, conflict
  );

  modport slave (
    input  push, push_hash, pop, load_valid, load_hash,
    output full, empty, conflict_mask, conflict
  );
endinterface

// File: rtl/lsq_hash_compare.sv
// One slot of the overlap check: purely combinational, no backpressure.
module lsq_hash_compare
  import cva5_types::*;
(
  input  logic       slot_valid_i,
  input  addr_hash_t slot_hash_i,
  input  addr_hash_t load_hash_i,
  output logic       match_o
);
  assign match_o = slot_valid_i && (slot_hash_i == load_hash_i);
endmodule

// File: rtl/store_hash_queue.sv
// Circular queue of in-flight store address hashes; loads query it combinationally (0 cycles).
// Push stalls only when full without a same-cycle pop; STORE_HASH_BYPASS_EN exposes same-cycle pushes.
module store_hash_queue
  import cva5_types::*;
  import cva5_config::*;
#(
  parameter int DEPTH = LSQ_STORE_HASH_DEPTH
) (
  input logic                 clk,
  input logic                 rst,
  store_hash_queue_if.slave   q
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  addr_hash_t       hash_q [DEPTH];

  logic push_acc;
  logic pop_acc;
  logic [DEPTH-1:0] slot_match;

  assign q.full  = (count_q == (PW+1)'(DEPTH));
  assign q.empty = (count_q == '0);

  // When full, a same-cycle pop frees the very slot being written.
  assign pop_acc  = q.pop && !q.empty;
  assign push_acc = q.push && (!q.full || q.pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (pop_acc) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push_acc) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    if (push_acc && !pop_acc) begin
      count_d = count_q + (PW+1)'(1);
    end else if (pop_acc && !push_acc) begin
      count_d = count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      hash_q[wr_ptr_q] <= q.push_hash;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    lsq_hash_compare u_cmp (
      .slot_valid_i (valid_q[i] && q.load_valid),
      .slot_hash_i  (hash_q[i]),
      .load_hash_i  (q.load_hash),
      .match_o      (slot_match[i])
    );
  end

`ifdef STORE_HASH_BYPASS_EN
  logic [DEPTH-1:0] bypass_mask;

  always_comb begin
    bypass_mask = '0;
    if (push_acc && q.load_valid && (q.push_hash == q.load_hash)) begin
      bypass_mask[wr_ptr_q] = 1'b1;
    end
  end

  assign q.conflict_mask = slot_match | bypass_mask;
`else
  assign q.conflict_mask = slot_match;
`endif

  assign q.conflict = |q.conflict_mask;

  // Overflow/underflow attempts must leave the queue untouched.
  a_push_full_no_pop: assert property (@(posedge clk) disable iff (rst)
    (q.push && q.full && !q.pop) |=> (q.full && $stable(wr_ptr_q)));
  a_pop_empty: assert property (@(posedge clk) disable iff (rst)
    (q.pop && q.empty && !q.push) |=> (q.empty && $stable(rd_ptr_q)));
endmodule

// File: tb/tb_store_hash_queue.sv
// Directed checks of the store hash queue with DEPTH=4, one task per scenario.
module tb_store_hash_queue;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  store_hash_queue_if #(.DEPTH(4)) sq ();

  store_hash_queue #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .q   (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef STORE_HASH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ps, input logic [3:0] ph, input logic pp,
                       input logic lv, input logic [3:0] lh);
    sq.push       = ps;
    sq.push_hash  = ph;
    sq.pop        = pp;
    sq.load_valid = lv;
    sq.load_hash  = lh;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 4'h0);
    #1;
    n_checks++; if (sq.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", sq.empty); end
    n_checks++; if (sq.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", sq.full); end
    n_checks++; if (sq.conflict_mask !== 4'b0000) begin n_fail++; $display("FAIL reset_mask got %b want 0000", sq.conflict_mask); end
    n_checks++; if (sq.conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict got %b want 0", sq.conflict); end
    drive(1'b0, 4'h0, 1'b1, 1'b0, 4'h0);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
    #1;
    n_checks++; if (sq.empty !== 1'b1) begin n_fail++; $display("FAIL pop_empty_ignored got empty=%b want 1", sq.empty); end
  endtask

  task automatic test_basic_query();
    do_reset();
    drive(1'b1, 4'h3, 1'b0, 1'b0, 4'h0); tick();
    drive(1'b1, 4'h5, 1'b0, 1'b0, 4'h0); tick();
    drive(1'b1, 4'h3, 1'b0, 1'b0, 4'h0); tick();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 4'h3);
    #1;
    n_checks++; if (sq.conflict_mask !== 4'b0101) begin n_fail++; $display("FAIL basic_mask3 got %b want 0101", sq.conflict_mask); end
    n_checks++; if (sq.conflict !== 1'b1) begin n_fail++; $display("FAIL basic_conflict3 got %b want 1", sq.conflict); end
    n_checks++; if (sq.empty !== 1'b0) begin n_fail++; $display("FAIL basic_empty got %b want 0", sq.empty); end
    drive(1'b0, 4'h0, 1'b0, 1'b1, 4'h5);
    #1;
    n_checks++; if (sq.conflict_mask !== 4'b0010) begin n_fail++; $display("FAIL basic_mask5 got %b want 0010", sq.conflict_mask); end
    drive(1'b0, 4'h0, 1'b0, 1'b1, 4'h7);
    #1;
    n_checks++; if (sq.conflict !== 1'b0) begin n_fail++; $display("FAIL basic_nomatch got %b want 0", sq.conflict); end
  endtask

  task automatic test_load_valid_off();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h3);
    #1;
    n_checks++; if (sq.conflict_mask !== 4'b0000) begin n_fail++; $display("FAIL lv_off_mask got %b want 0000", sq.conflict_mask); end
    n_checks++; if (sq.conflict !== 1'b0) begin n_fail++; $display("FAIL lv_off_conflict got %b want 0", sq.conflict); end
  endtask

  task automatic test_pop_same_cycle();
    drive(1'b0, 4'h0, 1'b1, 1'b1, 4'h3);
    #1;
    n_checks++; if (sq.conflict_mask !== 4'b0101) begin n_fail++; $display("FAIL pop_query_same got %b want 0101", sq.conflict_mask); end
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 4'h3);
    #1;
    n_checks++; if (sq.conflict_mask !== 4'b0100) begin n_fail++; $display("FAIL pop_query_after got %b want 0100", sq.conflict_mask); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b0, 4'h0);
      tick();
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
    #1;
    n_checks++; if (sq.full !== 1'b1) begin n_fail++; $display("FAIL full_set got %b want 1", sq.full); end
    n_checks++; if (sq.empty !== 1'b0) begin n_fail++; $display("FAIL full_empty got %b want 0", sq.empty); end
    drive(1'b1, 4'h9, 1'b0, 1'b1, 4'h9);
    #1;
    n_checks++; if (sq.conflict_mask !== 4'b0000) begin n_fail++; $display("FAIL rejected_push_visible got %b want 0000", sq.conflict_mask); end
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 4'h9);
    #1;
    n_checks++; if (sq.conflict_mask !== 4'b0000) begin n_fail++; $display("FAIL rejected_push_stored got %b want 0000", sq.conflict_mask); end
    drive(1'b0, 4'h0, 1'b0, 1'b1, 4'h1);
    #1;
    n_checks++; if (sq.conflict_mask !== 4'b0001) begin n_fail++; $display("FAIL rejected_push_clobber got %b want 0001", sq.conflict_mask); end
    n_checks++; if (sq.full !== 1'b1) begin n_fail++; $display("FAIL rejected_full got %b want 1", sq.full); end
    drive(1'b1, 4'h5, 1'b1, 1'b0, 4'h0); tick();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 4'h5);
    #1;
    n_checks++; if (sq.conflict_mask !== 4'b0001) begin n_fail++; $display("FAIL full_pp_slot0 got %b want 0001", sq.conflict_mask); end
    n_checks++; if (sq.full !== 1'b1) begin n_fail++; $display("FAIL full_pp_count got full=%b want 1", sq.full); end
    drive(1'b0, 4'h0, 1'b0, 1'b1, 4'h1);
    #1;
    n_checks++; if (sq.conflict_mask !== 4'b0000) begin n_fail++; $display("FAIL full_pp_old_gone got %b want 0000", sq.conflict_mask); end
    drive(1'b1, 4'h6, 1'b1, 1'b0, 4'h0); tick();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 4'h6);
    #1;
    n_checks++; if (sq.conflict_mask !== 4'b0010) begin n_fail++; $display("FAIL full_pp_slot1 got %b want 0010", sq.conflict_mask); end
    drive(1'b0, 4'h0, 1'b0, 1'b1, 4'h2);
    #1;
    n_checks++; if (sq.conflict_mask !== 4'b0000) begin n_fail++; $display("FAIL full_pp_rd_adv got %b want 0000", sq.conflict_mask); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 4'(i), 1'b1, 1'b0, 4'h0);
      tick();
    end
    drive(1'b0, 4'h0, 1'b0, 1'b1, 4'h6);
    #1;
    n_checks++; if (sq.conflict_mask !== 4'b0010) begin n_fail++; $display("FAIL wrap_slot1 got %b want 0010", sq.conflict_mask); end
    drive(1'b0, 4'h0, 1'b0, 1'b1, 4'h5);
    #1;
    n_checks++; if (sq.conflict_mask !== 4'b0000) begin n_fail++; $display("FAIL wrap_stale got %b want 0000", sq.conflict_mask); end
    n_checks++; if (sq.empty !== 1'b0 || sq.full !== 1'b0) begin n_fail++; $display("FAIL wrap_flags got empty=%b full=%b want 0 0", sq.empty, sq.full); end
  endtask

  task automatic test_bypass();
    do_reset();
    drive(1'b1, 4'hA, 1'b0, 1'b1, 4'hA);
    #1;
    n_checks++; if (sq.conflict !== BYP) begin n_fail++; $display("FAIL bypass_same_cycle got %b want %b", sq.conflict, BYP); end
    n_checks++; if (sq.conflict_mask !== {3'b000, BYP}) begin n_fail++; $display("FAIL bypass_mask got %b want %b", sq.conflict_mask, {3'b000, BYP}); end
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 4'hA);
    #1;
    n_checks++; if (sq.conflict !== 1'b1) begin n_fail++; $display("FAIL bypass_next_cycle got %b want 1", sq.conflict); end
  endtask

  task automatic test_reset_priority();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b0, 4'h0);
      tick();
    end
    rst = 1'b1;
    drive(1'b1, 4'h1, 1'b0, 1'b0, 4'h0);
    tick();
    rst = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b1, 4'h1);
    #1;
    n_checks++; if (sq.empty !== 1'b1) begin n_fail++; $display("FAIL rstprio_empty got %b want 1", sq.empty); end
    n_checks++; if (sq.conflict_mask !== 4'b0000) begin n_fail++; $display("FAIL rstprio_mask got %b want 0000", sq.conflict_mask); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
    test_reset();
    test_basic_query();
    test_load_valid_off();
    test_pop_same_cycle();
    test_full();
    test_wrap();
    test_bypass();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
